// File: rtl/dcm_rst_ctrl.sv
// dcm_rst_ctrl: reset sequencer for a DCM/clock manager.
//
// The controller pulses the DCM reset, waits for a lock with a timeout, and
// retries a bounded number of times. It then requires a run of consecutive
// lock cycles before it releases the system reset. A loss of lock while
// running restarts the whole sequence and leaves a sticky LOST flag.
//
// Ports
//   CLK_IN        : single clock, rising edge.
//   RST_IN        : asynchronous active-high reset.
//   LOCKED_IN     : DCM LOCKED, asynchronous to CLK_IN (double-synchronised).
//   DCM_RST_OUT   : reset to the DCM RST pin.
//   SYS_RST_OUT   : active-high reset for logic in the DCM output domains.
//   READY_OUT     : high in RUN.
//   FAIL_OUT      : high in FAIL (terminal until RST_IN).
//   LOST_OUT      : sticky, lock dropped while in RUN.
//   RETRY_CNT_OUT : current retry count.
//   STATE_OUT     : HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.
module dcm_rst_ctrl #(
    parameter int unsigned DCM_RST_CYCLES = 3,
    parameter int unsigned LOCK_TIMEOUT   = 1000,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned MAX_RETRY      = 7
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       LOCKED_IN,
    output logic       DCM_RST_OUT,
    output logic       SYS_RST_OUT,
    output logic       READY_OUT,
    output logic       FAIL_OUT,
    output logic       LOST_OUT,
    output logic [3:0] RETRY_CNT_OUT,
    output logic [2:0] STATE_OUT
);

    localparam logic [7:0]  HoldLast    = 8'(DCM_RST_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]  StableLast  = 8'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RetryMax    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StHold   = 3'd0,
        StWait   = 3'd1,
        StStable = 3'd2,
        StRun    = 3'd3,
        StFail   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        lock_meta_q;
    logic        lock_s_q;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  stable_cnt_q, stable_cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        lost_q, lost_d;

    logic        dcm_rst_q, dcm_rst_d;
    logic        sys_rst_q, sys_rst_d;
    logic        ready_q, ready_d;
    logic        fail_q, fail_d;

    // State register, synchroniser and registered outputs.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q      <= StHold;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            hold_cnt_q   <= '0;
            timer_q      <= '0;
            stable_cnt_q <= '0;
            retry_q      <= '0;
            lost_q       <= 1'b0;
            dcm_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_meta_q  <= LOCKED_IN;
            lock_s_q     <= lock_meta_q;
            hold_cnt_q   <= hold_cnt_d;
            timer_q      <= timer_d;
            stable_cnt_q <= stable_cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            dcm_rst_q    <= dcm_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    // Next-state logic. Counters default to zero so every state is entered
    // with fresh counts; a counter only advances while its state is held.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = '0;
        timer_d      = '0;
        stable_cnt_d = '0;
        retry_d      = retry_q;
        lost_d       = lost_q;
        case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = StWait;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StWait: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (lock_s_q) begin
                    state_d = StStable;
                end else if (timer_q == TimeoutLast) begin
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + 4'd1;
                        state_d = StHold;
                    end else begin
                        state_d = StFail;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StStable: begin
                if (!lock_s_q) begin
                    state_d = StWait;
                end else if (stable_cnt_q == StableLast) begin
                    state_d = StRun;
                end else begin
                    stable_cnt_d = stable_cnt_q + 8'd1;
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    state_d = StHold;
                    retry_d = '0;
                    lost_d  = 1'b1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register. DCM reset implies system reset.
    always_comb begin
        dcm_rst_d = (state_d == StHold) || (state_d == StFail);
        sys_rst_d = (state_d != StRun);
        ready_d   = (state_d == StRun);
        fail_d    = (state_d == StFail);
    end

    assign DCM_RST_OUT   = dcm_rst_q;
    assign SYS_RST_OUT   = sys_rst_q;
    assign READY_OUT     = ready_q;
    assign FAIL_OUT      = fail_q;
    assign LOST_OUT      = lost_q;
    assign RETRY_CNT_OUT = retry_q;
    assign STATE_OUT     = state_q;

endmodule

// File: tb/tb_dcm_rst_ctrl.sv
// Self-checking bench for dcm_rst_ctrl with default parameters.
module tb_dcm_rst_ctrl;

    localparam int DcmRstCycles = 3;
    localparam int LockTimeout  = 1000;
    localparam int StableCycles = 16;
    localparam int MaxRetry     = 7;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       dcm_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lost;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    dcm_rst_ctrl #(
        .DCM_RST_CYCLES (DcmRstCycles),
        .LOCK_TIMEOUT   (LockTimeout),
        .STABLE_CYCLES  (StableCycles),
        .MAX_RETRY      (MaxRetry)
    ) dut (
        .CLK_IN        (clk),
        .RST_IN        (rst),
        .LOCKED_IN     (lock),
        .DCM_RST_OUT   (dcm_rst),
        .SYS_RST_OUT   (sys_rst),
        .READY_OUT     (ready),
        .FAIL_OUT      (fail),
        .LOST_OUT      (lost),
        .RETRY_CNT_OUT (retry_cnt),
        .STATE_OUT     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Reference model: phase code, edges spent in the phase, consecutive
    // lock count, retries, sticky lost, and a two-deep sync pipeline.
    int m_phase;
    int m_age;
    int m_ones;
    int m_retries;
    bit m_lost;
    bit m_s1;
    bit m_s2;

    localparam logic [11:0] ResetVec = 12'b000_1_1_0_0_0_0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_age     = 0;
        m_ones    = 0;
        m_retries = 0;
        m_lost    = 1'b0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    task automatic model_tick(input bit lock_v);
        bit seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lock_v;
        case (m_phase)
            0: begin
                m_age++;
                if (m_age == DcmRstCycles) begin
                    m_phase = 1;
                    m_age   = 0;
                end
            end
            1: begin
                if (seen) begin
                    m_phase = 2;
                    m_ones  = 0;
                end else begin
                    m_age++;
                    if (m_age == LockTimeout) begin
                        m_age = 0;
                        if (m_retries < MaxRetry) begin
                            m_retries++;
                            m_phase = 0;
                        end else begin
                            m_phase = 4;
                        end
                    end
                end
            end
            2: begin
                if (seen) begin
                    m_ones++;
                    if (m_ones == StableCycles) m_phase = 3;
                end else begin
                    m_phase = 1;
                    m_age   = 0;
                end
            end
            3: begin
                if (!seen) begin
                    m_phase   = 0;
                    m_age     = 0;
                    m_retries = 0;
                    m_lost    = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [11:0] model_vec();
        model_vec = {3'(m_phase), (m_phase == 0) || (m_phase == 4), m_phase != 3,
                     m_phase == 3, m_phase == 4, m_lost, 4'(m_retries)};
    endfunction

    function automatic logic [11:0] dut_vec();
        dut_vec = {state, dcm_rst, sys_rst, ready, fail, lost, retry_cnt};
    endfunction

    // One rising edge, then compare everything on the falling edge.
    task automatic step();
        @(posedge clk);
        model_tick(lock);
        edge_n++;
        @(negedge clk);
        check_eq("outputs", 32'(dut_vec()), 32'(model_vec()));
        check_eq("sys_rst_low_with_dcm_rst", 32'(dcm_rst & ~sys_rst), 32'd0);
    endtask

    // Called between edges; checks the asynchronous effect before any edge.
    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("async_reset", 32'(dut_vec()), 32'(ResetVec));
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int seg_left;
        rst  = 1'b0;
        lock = 1'b0;
        #2;

        // Nominal lock, then a one-cycle lock loss and relock.
        apply_reset();
        lock = 1'b0;
        while (edge_n < 70) begin
            if (edge_n == 9)  lock = 1'b1;
            if (edge_n == 40) lock = 1'b0;
            if (edge_n == 41) lock = 1'b1;
            step();
            case (edge_n)
                2:  check_eq("dcm_rst_e2", 32'(dcm_rst), 32'd1);
                3:  check_eq("dcm_rst_e3", 32'(dcm_rst), 32'd0);
                11: check_eq("state_e11", 32'(state), 32'd1);
                12: check_eq("state_e12", 32'(state), 32'd2);
                27: check_eq("sys_rst_e27", 32'(sys_rst), 32'd1);
                28: begin
                    check_eq("sys_rst_e28", 32'(sys_rst), 32'd0);
                    check_eq("ready_e28", 32'(ready), 32'd1);
                end
                42: check_eq("state_before_loss", 32'(state), 32'd3);
                43: begin
                    check_eq("loss_state", 32'(state), 32'd0);
                    check_eq("loss_sys_rst", 32'(sys_rst), 32'd1);
                    check_eq("loss_lost", 32'(lost), 32'd1);
                    check_eq("loss_retry", 32'(retry_cnt), 32'd0);
                end
                62: check_eq("relock_not_yet", 32'(state), 32'd2);
                63: begin
                    check_eq("relock_ready", 32'(ready), 32'd1);
                    check_eq("relock_lost_sticky", 32'(lost), 32'd1);
                end
                default: ;
            endcase
        end

        // Reset pulse while in RUN.
        apply_reset();

        // Lock synchronised exactly on the timeout cycle.
        lock = 1'b0;
        while (edge_n < 1006) begin
            if (edge_n == 1000) lock = 1'b1;
            step();
            if (edge_n == 1002) check_eq("collide_pre_state", 32'(state), 32'd1);
            if (edge_n == 1003) begin
                check_eq("collide_state", 32'(state), 32'd2);
                check_eq("collide_retry", 32'(retry_cnt), 32'd0);
            end
        end

        // One timeout, then a 2-cycle glitch after 10 stable cycles.
        apply_reset();
        lock = 1'b0;
        while (edge_n < 1050) begin
            if (edge_n == 1009) lock = 1'b1;
            if (edge_n == 1020) lock = 1'b0;
            if (edge_n == 1022) lock = 1'b1;
            step();
            case (edge_n)
                1003: check_eq("retry_after_timeout", 32'(retry_cnt), 32'd1);
                1012: check_eq("glitch_stable_entry", 32'(state), 32'd2);
                1023: begin
                    check_eq("glitch_to_wait", 32'(state), 32'd1);
                    check_eq("glitch_retry", 32'(retry_cnt), 32'd1);
                end
                1025: check_eq("glitch_restable", 32'(state), 32'd2);
                1040: check_eq("glitch_fresh_count", 32'(state), 32'd2);
                1041: check_eq("glitch_run", 32'(state), 32'd3);
                default: ;
            endcase
        end

        // No lock at all: exhaust the retries and land in FAIL.
        apply_reset();
        lock = 1'b0;
        while (edge_n < 8050) begin
            step();
            if (edge_n == 8023) check_eq("fail_not_yet", 32'(fail), 32'd0);
            if (edge_n == 8024) begin
                check_eq("fail_flag", 32'(fail), 32'd1);
                check_eq("fail_retry", 32'(retry_cnt), 32'd7);
                check_eq("fail_state", 32'(state), 32'd4);
            end
        end
        check_eq("fail_terminal", 32'(state), 32'd4);

        // Reset pulse while in FAIL.
        apply_reset();

        // Random lock traffic with occasional mid-run resets.
        for (int iter = 0; iter < 6; iter++) begin
            apply_reset();
            seg_left = 0;
            for (int c = 0; c < 600; c++) begin
                if (seg_left == 0) begin
                    lock     = ($urandom_range(0, 3) != 0);
                    seg_left = lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
                end
                seg_left--;
                if ($urandom_range(0, 299) == 0) apply_reset();
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcm_rst_ctrl.md
DCM_RST_CTRL -- requirements
Module: dcm_rst_ctrl

Interface
REQ-001 SHALL have parameter DCM_RST_CYCLES, default 3, meaning the number of CLK_IN cycles DCM_RST_OUT is held high per attempt (range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000, meaning the maximum number of WAIT cycles allowed for lock per attempt (range 2..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 16, meaning the number of consecutive synchronized-lock cycles required before release (range 1..255).
REQ-004 SHALL have parameter MAX_RETRY, default 7, meaning the number of re-attempts before FAIL (range 0..15).
REQ-005 SHALL have port CLK_IN, input, 1 bit: the single clock; all flops use its rising edge.
REQ-006 SHALL have port RST_IN, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port LOCKED_IN, input, 1 bit: the DCM LOCKED output, asynchronous to CLK_IN.
REQ-008 SHALL have port DCM_RST_OUT, output, 1 bit: the reset driven to the DCM RST input.
REQ-009 SHALL have port SYS_RST_OUT, output, 1 bit: the active-high system reset for logic clocked by the DCM outputs.
REQ-010 SHALL have port READY_OUT, output, 1 bit: high in RUN.
REQ-011 SHALL have port FAIL_OUT, output, 1 bit: high in FAIL.
REQ-012 SHALL have port LOST_OUT, output, 1 bit: sticky flag, lock was lost while in RUN.
REQ-013 SHALL have port RETRY_CNT_OUT, output, 4 bits: the current retry count.
REQ-014 SHALL have port STATE_OUT, output, 3 bits: the state code, HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.

Function
REQ-015 SHALL synchronize LOCKED_IN through two flops; lock_s is the second stage, and all decisions use lock_s only.
REQ-016 SHALL register every output; no output is a combinational function of LOCKED_IN.
REQ-017 In HOLD, SHALL drive DCM_RST_OUT=1, SYS_RST_OUT=1, and count DCM_RST_CYCLES edges, then go to WAIT; DCM_RST_OUT falls on that same edge.
REQ-018 In HOLD, SHALL ignore lock_s.
REQ-019 In WAIT, SHALL increment a 16-bit timer each cycle.
REQ-020 In WAIT with lock_s=1, SHALL go to STABLE and clear the timer.
REQ-021 In WAIT, when the timer reaches LOCK_TIMEOUT-1 with lock_s=0: if retry count < MAX_RETRY, SHALL increment the retry count and go to HOLD; otherwise SHALL go to FAIL.
REQ-022 In WAIT, when lock_s=1 coincides with the timeout cycle, the lock SHALL win (go to STABLE).
REQ-023 In STABLE, SHALL count consecutive cycles with lock_s=1, and after STABLE_CYCLES such cycles go to RUN.
REQ-024 In STABLE, a lock_s=0 cycle SHALL return the block to WAIT with timer and stable counter cleared; the retry count is unchanged.
REQ-025 On entering RUN, SYS_RST_OUT SHALL fall and READY_OUT SHALL rise on the same edge.
REQ-026 In RUN with lock_s=0, on the next edge SHALL: go to HOLD, set SYS_RST_OUT=1, DCM_RST_OUT=1, READY_OUT=0 and LOST_OUT=1, and clear the retry count to 0.
REQ-027 FAIL SHALL be terminal until RST_IN, with DCM_RST_OUT=1, SYS_RST_OUT=1, FAIL_OUT=1 and READY_OUT=0.
REQ-028 Latency: with LOCKED_IN stable high before edge k while in WAIT, STABLE SHALL be entered after edge k+2 and RUN after edge k+2+STABLE_CYCLES.
REQ-029 SYS_RST_OUT SHALL never be 0 while DCM_RST_OUT=1.

Reset
REQ-030 RST_IN=1 SHALL immediately force: state HOLD, DCM_RST_OUT=1, SYS_RST_OUT=1, READY_OUT=0, FAIL_OUT=0, LOST_OUT=0, RETRY_CNT_OUT=0, all counters and sync flops 0, regardless of the current state.
REQ-031 After RST_IN deasserts, the first counted HOLD edge SHALL be the first rising edge of CLK_IN.
REQ-032 RST_IN asserted mid-attempt (in any state, including FAIL) SHALL restart a full sequence.

Verification
REQ-033 Defaults, LOCKED_IN rises before edge 10 -> DCM_RST_OUT falls after edge 3; STATE_OUT=2 after edge 12; SYS_RST_OUT=0 and READY_OUT=1 after edge 28.
REQ-034 Defaults, LOCKED_IN held 0 -> 7 retries, each HOLD 3 cycles + WAIT 1000 cycles; FAIL_OUT=1 and RETRY_CNT_OUT=7 after edge 8024; then stays there.
REQ-035 Lock-loss test: RUN, then LOCKED_IN low for 1 cycle -> SYS_RST_OUT=1, LOST_OUT=1, RETRY_CNT_OUT=0, STATE_OUT=0 three edges after the drop; then a normal relock reaches RUN with LOST_OUT still 1.
REQ-036 Glitch in STABLE: LOCKED_IN low 2 cycles after 10 stable cycles -> return to WAIT, RETRY_CNT_OUT unchanged, and RUN requires 16 fresh cycles.
REQ-037 Timeout collision: LOCKED_IN synchronized high exactly at timer=999 -> STATE_OUT=2, retry count not incremented.
REQ-038 RST_IN pulse during FAIL and during RUN -> all outputs return to reset values asynchronously (before the next CLK_IN edge).
